// File: rtl/ram_stream_loader_if.sv
// Byte-stream input and single RAM write port used by the boot-time image loader.
interface ram_stream_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        ram_req;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_rvalid;

    modport master (
        input  byte_valid, byte_data, ram_rvalid,
        output byte_ready, ram_req, ram_we, ram_be, ram_addr, ram_wdata
    );

    modport slave (
        output byte_valid, byte_data, ram_rvalid,
        input  byte_ready, ram_req, ram_we, ram_be, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_stream_loader.sv
// Parses a framed image (base, count, payload, XOR checksum) from a byte stream and
// writes it word by word into RAM, holding the core in reset while loading.
module ram_stream_loader #(
    parameter int unsigned MemWords = 16384,
    parameter logic [31:0] AddrBase = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    ram_stream_loader_if.master        bus,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic                       core_rst_no
);

    typedef enum logic [3:0] {
        S_IDLE, S_HADDR, S_HLEN, S_DATA, S_WRITE, S_WAIT, S_CSUM, S_DONE, S_ERR
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q;
    logic [23:0] shift_q;
    logic [31:0] cur_addr_q;
    logic [31:0] remaining_q;
    logic [7:0]  csum_q;
    logic        done_q, err_q;
    logic [31:0] addr_out_q, wdata_q;

    logic        xfer, last_byte, armed, hdr_bad, csum_ok;
    logic [31:0] field, off_words;
    logic [32:0] span;

    assign xfer      = bus.byte_valid && bus.byte_ready;
    assign last_byte = (byte_cnt_q == 2'd3);
    assign field     = {bus.byte_data, shift_q};
    assign armed     = start_i && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign csum_ok   = (bus.byte_data == csum_q);

    // Range check in 33 bits so a huge count cannot wrap back into range.
    assign off_words = (cur_addr_q - AddrBase) >> 2;
    assign span      = {1'b0, off_words} + {1'b0, field};
    assign hdr_bad   = (cur_addr_q[1:0] != 2'b00) || (cur_addr_q < AddrBase) ||
                       (span > 33'(MemWords));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start_i) state_d = S_HADDR;
            S_HADDR: if (xfer && last_byte) state_d = S_HLEN;
            S_HLEN: begin
                if (xfer && last_byte) begin
                    if (hdr_bad)            state_d = S_ERR;
                    else if (field == '0)   state_d = S_CSUM;
                    else                    state_d = S_DATA;
                end
            end
            S_DATA:  if (xfer && last_byte) state_d = S_WRITE;
            S_WRITE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.ram_rvalid) state_d = (remaining_q == 32'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM:  if (xfer) state_d = csum_ok ? S_DONE : S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.byte_ready = 1'b0;
        bus.ram_req    = 1'b0;
        bus.ram_we     = 1'b0;
        bus.ram_be     = 4'h0;
        busy_o         = 1'b1;
        case (state_q)
            S_HADDR, S_HLEN, S_DATA, S_CSUM: bus.byte_ready = 1'b1;
            S_WRITE: begin
                bus.ram_req = 1'b1;
                bus.ram_we  = 1'b1;
                bus.ram_be  = 4'hF;
            end
            S_IDLE, S_DONE, S_ERR: busy_o = 1'b0;
            default: ;
        endcase
    end

    assign core_rst_no   = !busy_o;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign bus.ram_addr  = addr_out_q;
    assign bus.ram_wdata = wdata_q;

    // Field assembly, checksum and address/count bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_q  <= 2'd0;
            shift_q     <= '0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            csum_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            addr_out_q  <= '0;
            wdata_q     <= '0;
        end else if (armed) begin
            byte_cnt_q <= 2'd0;
            csum_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (xfer && state_q != S_CSUM) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                shift_q    <= {bus.byte_data, shift_q[23:8]};
            end
            case (state_q)
                S_HADDR: if (xfer && last_byte) cur_addr_q <= field;
                S_HLEN: begin
                    if (xfer && last_byte) begin
                        remaining_q <= field;
                        if (hdr_bad) err_q <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum_q <= csum_q ^ bus.byte_data;
                        if (last_byte) begin
                            wdata_q    <= field;
                            addr_out_q <= cur_addr_q;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.ram_rvalid) begin
                        cur_addr_q  <= cur_addr_q + 32'd4;
                        remaining_q <= remaining_q - 32'd1;
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        done_q <= csum_ok;
                        err_q  <= !csum_ok;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
